seg_display_arbiter: RTL and testbench

//  Shares the single 4-digit seven-segment display among NUM_REQ requesters (PC, ALU result, mem data, ...).

---
 rtl/seg_disp_pkg.sv | 13 +
 rtl/seg_display_arbiter_rr_pick.sv | 26 ++
 rtl/seg_display_arbiter.sv | 145 ++++++++++++++
 tb/tb_seg_display_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FORCE = 2'd2
   } state_t;

   localparam int DIGIT_W = 4;
   localparam int DIGITS  = 4;

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start,
// wrapping around, returned one-hot.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int SEL_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   start,
   output logic [NUM_REQ-1:0] pick,
   output logic               found
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [2*NUM_REQ-1:0] pick_dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [NUM_REQ-1:0]   rot_pick;

   // Rotate so start lands on bit 0, isolate the lowest set bit, rotate back.
   assign req_dbl  = {req, req} >> start;
   assign rot      = req_dbl[NUM_REQ-1:0];
   assign rot_pick = rot & (-rot);
   assign pick_dbl = {rot_pick, rot_pick} << start;
   assign pick     = pick_dbl[2*NUM_REQ-1:NUM_REQ];
   assign found    = |rot;

endmodule

// File: rtl/seg_display_arbiter.sv
// Time-shares one 4-digit hex display among NUM_REQ sources: round-robin with
// a minimum dwell per grant, a lock that freezes rotation and a force override.
module seg_display_arbiter
   import seg_disp_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DWELL_CYCLES = 100_000_000,
   parameter int CNT_W        = 27,
   parameter int SEL_W        = 2
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [DIGIT_W*DIGITS*NUM_REQ-1:0]   data,
   input  logic                                lock,
   input  logic                                force_en,
   input  logic [SEL_W-1:0]                    force_sel,
   output logic [NUM_REQ-1:0]                  grant,
   output logic [DIGIT_W-1:0]                  hex0,
   output logic [DIGIT_W-1:0]                  hex1,
   output logic [DIGIT_W-1:0]                  hex2,
   output logic [DIGIT_W-1:0]                  hex3,
   output logic                                valid,
   output logic                                switch_pulse
);

   // state | meaning
   // IDLE  | no requester granted, display blank
   // HOLD  | owner granted, dwell counter running (frozen while lock=1)
   // FORCE | force_sel pinned to the display, counter frozen

   localparam int                 WORD_W   = DIGIT_W * DIGITS;
   localparam logic [SEL_W-1:0]   LAST_IDX = SEL_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

   function automatic logic [SEL_W-1:0] inc_idx(input logic [SEL_W-1:0] i);
      return (i == LAST_IDX) ? '0 : i + SEL_W'(1);
   endfunction

   state_t              state, nxt_state;
   logic [NUM_REQ-1:0]  nxt_grant;
   logic [NUM_REQ-1:0]  pick;
   logic                found;
   logic [SEL_W-1:0]    owner, nxt_owner;
   logic [SEL_W-1:0]    rr_ptr, nxt_ptr;
   logic [SEL_W-1:0]    pick_idx;
   logic [CNT_W-1:0]    cnt, nxt_cnt;
   logic                force_ok;
   logic                rearb;
   logic [WORD_W-1:0]   nxt_data;

   assign force_ok = force_en && (int'(force_sel) < NUM_REQ);

   // rr_ptr always equals owner+1 while holding, so one picker start serves
   // idle arbitration, dwell expiry, owner drop and force release alike.
   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .SEL_W   (SEL_W)
   ) u_rr_pick (
      .req   (req),
      .start (rr_ptr),
      .pick  (pick),
      .found (found)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_idx = SEL_W'(i);
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_grant = grant;
      nxt_owner = owner;
      nxt_cnt   = cnt;
      nxt_ptr   = rr_ptr;
      rearb     = 1'b0;
      if (force_ok) begin
         nxt_state = FORCE;
         nxt_owner = force_sel;
         nxt_ptr   = inc_idx(force_sel);
         for (int i = 0; i < NUM_REQ; i++) begin
            nxt_grant[i] = (force_sel == SEL_W'(i));
         end
      end else begin
         case (state)
            HOLD: begin
               if (!req[owner] || (cnt == '0 && !lock)) rearb = 1'b1;
               else if (!lock) nxt_cnt = cnt - CNT_W'(1);
            end
            default: rearb = 1'b1;
         endcase
         if (rearb) begin
            if (found) begin
               nxt_state = HOLD;
               nxt_grant = pick;
               nxt_owner = pick_idx;
               nxt_cnt   = CNT_LOAD;
               nxt_ptr   = inc_idx(pick_idx);
            end else begin
               nxt_state = IDLE;
               nxt_grant = '0;
            end
         end
      end
   end

   always_comb begin
      nxt_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (nxt_grant[i]) nxt_data = data[WORD_W*i +: WORD_W];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         grant        <= '0;
         owner        <= '0;
         cnt          <= '0;
         rr_ptr       <= '0;
         valid        <= 1'b0;
         switch_pulse <= 1'b0;
         hex0         <= '0;
         hex1         <= '0;
         hex2         <= '0;
         hex3         <= '0;
      end else begin
         state        <= nxt_state;
         grant        <= nxt_grant;
         owner        <= nxt_owner;
         cnt          <= nxt_cnt;
         rr_ptr       <= nxt_ptr;
         valid        <= |nxt_grant;
         switch_pulse <= (nxt_grant != grant);
         hex0         <= nxt_data[DIGIT_W-1:0];
         hex1         <= nxt_data[2*DIGIT_W-1:DIGIT_W];
         hex2         <= nxt_data[3*DIGIT_W-1:2*DIGIT_W];
         hex3         <= nxt_data[4*DIGIT_W-1:3*DIGIT_W];
      end
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a 4-cycle dwell.
module tb_seg_display_arbiter;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [63:0] data;
   logic        lock;
   logic        force_en;
   logic [1:0]  force_sel;
   logic [3:0]  grant;
   logic [3:0]  hex0, hex1, hex2, hex3;
   logic        valid;
   logic        switch_pulse;

   int errors = 0;
   int checks = 0;

   seg_display_arbiter #(
      .NUM_REQ      (4),
      .DWELL_CYCLES (4),
      .CNT_W        (3),
      .SEL_W        (2)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req          (req),
      .data         (data),
      .lock         (lock),
      .force_en     (force_en),
      .force_sel    (force_sel),
      .grant        (grant),
      .hex0         (hex0),
      .hex1         (hex1),
      .hex2         (hex2),
      .hex3         (hex3),
      .valid        (valid),
      .switch_pulse (switch_pulse)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      req = 4'b0000;
      do_reset();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000); end
      checks++; if ({hex3, hex2, hex1, hex0} !== 16'h0000) begin errors++; $display("FAIL reset_hex got=%h exp=%h", {hex3, hex2, hex1, hex0}, 16'h0000); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (switch_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", switch_pulse); end
      req = 4'b0001;
      step();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL first_grant got=%b exp=%b", grant, 4'b0001); end
      checks++; if ({hex3, hex2, hex1, hex0} !== 16'h1234) begin errors++; $display("FAIL first_hex got=%h exp=%h", {hex3, hex2, hex1, hex0}, 16'h1234); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", valid); end
      checks++; if (switch_pulse !== 1'b1) begin errors++; $display("FAIL first_pulse got=%b exp=1", switch_pulse); end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_g;
      logic       exp_p;
      req = 4'b1011;
      do_reset();
      for (int k = 0; k < 13; k++) begin
         step();
         exp_g = (k < 4) ? 4'b0001 : (k < 8) ? 4'b0010 : (k < 12) ? 4'b1000 : 4'b0001;
         exp_p = (k % 4 == 0);
         checks++; if (grant !== exp_g) begin errors++; $display("FAIL rot_grant cyc=%0d got=%b exp=%b", k, grant, exp_g); end
         checks++; if (switch_pulse !== exp_p) begin errors++; $display("FAIL rot_pulse cyc=%0d got=%b exp=%b", k, switch_pulse, exp_p); end
         if (k == 4) begin
            checks++; if ({hex3, hex2, hex1, hex0} !== 16'h5678) begin errors++; $display("FAIL rot_hex got=%h exp=%h", {hex3, hex2, hex1, hex0}, 16'h5678); end
         end
      end
   endtask

   task automatic test_lock();
      int n;
      n = 0;
      step();
      while (grant !== 4'b0010 && n < 10) begin
         step();
         n++;
      end
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL lock_setup_timeout got=%b exp=%b", grant, 4'b0010); end
      step();
      lock = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         checks++; if (grant !== 4'b0010 || switch_pulse !== 1'b0) begin errors++; $display("FAIL lock_hold cyc=%0d got=%b/%b exp=0010/0", k, grant, switch_pulse); end
      end
      lock = 1'b0;
      step();
      step();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL lock_remaining got=%b exp=%b", grant, 4'b0010); end
      step();
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL lock_resume got=%b exp=%b", grant, 4'b1000); end
   endtask

   task automatic test_owner_drop();
      req = 4'b1010;
      do_reset();
      step();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL drop_setup got=%b exp=%b", grant, 4'b0010); end
      step();
      req = 4'b1000;
      step();
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL drop_regrant got=%b exp=%b", grant, 4'b1000); end
      checks++; if (switch_pulse !== 1'b1) begin errors++; $display("FAIL drop_pulse got=%b exp=1", switch_pulse); end
      checks++; if ({hex3, hex2, hex1, hex0} !== 16'hDEF0) begin errors++; $display("FAIL drop_hex got=%h exp=%h", {hex3, hex2, hex1, hex0}, 16'hDEF0); end
      req = 4'b0000;
      step();
      checks++; if (grant !== 4'b0000 || valid !== 1'b0) begin errors++; $display("FAIL drop_idle got=%b/%b exp=0000/0", grant, valid); end
      checks++; if (switch_pulse !== 1'b1) begin errors++; $display("FAIL drop_idle_pulse got=%b exp=1", switch_pulse); end
      checks++; if ({hex3, hex2, hex1, hex0} !== 16'h0000) begin errors++; $display("FAIL drop_idle_hex got=%h exp=%h", {hex3, hex2, hex1, hex0}, 16'h0000); end
      step();
      checks++; if (switch_pulse !== 1'b0) begin errors++; $display("FAIL idle_no_pulse got=%b exp=0", switch_pulse); end
   endtask

   task automatic test_force();
      req = 4'b0001;
      do_reset();
      step();
      step();
      step();
      force_en  = 1'b1;
      force_sel = 2'd2;
      step();
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL force_grant got=%b exp=%b", grant, 4'b0100); end
      checks++; if ({hex3, hex2, hex1, hex0} !== 16'h9ABC) begin errors++; $display("FAIL force_hex got=%h exp=%h", {hex3, hex2, hex1, hex0}, 16'h9ABC); end
      checks++; if (switch_pulse !== 1'b1) begin errors++; $display("FAIL force_pulse got=%b exp=1", switch_pulse); end
      force_sel = 2'd3;
      step();
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL force_sel_change got=%b exp=%b", grant, 4'b1000); end
      force_en = 1'b0;
      step();
      checks++; if (grant !== 4'b0001 || switch_pulse !== 1'b1) begin errors++; $display("FAIL force_release got=%b/%b exp=0001/1", grant, switch_pulse); end
      req = 4'b0011;
      step();
      step();
      step();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL force_reload got=%b exp=%b", grant, 4'b0001); end
      step();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL force_reload_rot got=%b exp=%b", grant, 4'b0010); end
   endtask

   task automatic test_reset_mid();
      req = 4'b1111;
      do_reset();
      for (int k = 0; k < 6; k++) step();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL mid_setup got=%b exp=%b", grant, 4'b0010); end
      reset = 1'b1;
      step();
      checks++; if (grant !== 4'b0000 || valid !== 1'b0 || switch_pulse !== 1'b0) begin errors++; $display("FAIL mid_reset got=%b/%b/%b exp=0000/0/0", grant, valid, switch_pulse); end
      checks++; if ({hex3, hex2, hex1, hex0} !== 16'h0000) begin errors++; $display("FAIL mid_reset_hex got=%h exp=%h", {hex3, hex2, hex1, hex0}, 16'h0000); end
      reset = 1'b0;
      step();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got=%b exp=%b", grant, 4'b0001); end
   endtask

   initial begin
      reset     = 1'b1;
      req       = 4'b0000;
      data      = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
      lock      = 1'b0;
      force_en  = 1'b0;
      force_sel = 2'd0;
      test_reset();
      test_rotation();
      test_lock();
      test_owner_drop();
      test_force();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
